// File: rtl/io_input_buffer_if.sv
// io_input_buffer_if
//   Bundles the producer-side valid/ready handshake and the CPU-side pop and
//   status signals of the accumulator CPU input buffer.
//   master : drives in_data/in_valid/rd_en/clr_err and observes the outputs
//            (producer + CPU side, e.g. the testbench)
//   slave  : the buffer itself
//   Signals: in_data, in_valid, in_ready, rd_en, clr_err, mem_in, empty, full,
//            count, underflow
interface io_input_buffer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              rd_en;
    logic              clr_err;
    logic [DATA_W-1:0] mem_in;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              underflow;

    modport master (
        output in_data, in_valid, rd_en, clr_err,
        input  in_ready, mem_in, empty, full, count, underflow
    );

    modport slave (
        input  in_data, in_valid, rd_en, clr_err,
        output in_ready, mem_in, empty, full, count, underflow
    );
endinterface

// File: rtl/io_input_buffer.sv
// io_input_buffer
//   Upstream stage of the accumulator CPU input port. Words from an external
//   producer (valid/ready) are queued in a DEPTH-entry FIFO; the head word is
//   presented combinationally on mem_in (EMPTY_VALUE while empty). The CPU pops
//   with rd_en. A sticky underflow flag records rd_en seen while empty and is
//   cleared by clr_err (a new set in the same cycle wins).
//   Ports: CLK (rising edge), reset (sync, active-high), bus (slave modport of
//   io_input_buffer_if: in_data/in_valid/in_ready, rd_en, clr_err, mem_in,
//   empty, full, count, underflow).
//   Optional feature: define IO_BYPASS_EN to forward in_data to mem_in while
//   empty; a simultaneous rd_en then consumes the word without storing it.
module io_input_buffer #(
    parameter int              DATA_W      = 16,
    parameter int              DEPTH       = 4,
    parameter int              ADDR_W      = 2,
    parameter logic [DATA_W-1:0] EMPTY_VALUE = '0
) (
    input logic                CLK,
    input logic                reset,
    io_input_buffer_if.slave   bus
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              underflow;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic uf_set;
    logic bypass_take;

    assign empty = (count == '0);
    assign full  = (count == (ADDR_W+1)'(DEPTH));

    // A full buffer refuses the push even if a pop happens the same cycle.
    assign bus.in_ready = !full && !reset;

`ifdef IO_BYPASS_EN
    // Word handed straight to the CPU: never stored, never an underflow.
    assign bypass_take = empty && bus.in_valid && bus.rd_en;
    assign bus.mem_in  = !empty        ? mem[rd_ptr] :
                         bus.in_valid  ? bus.in_data : EMPTY_VALUE;
`else
    assign bypass_take = 1'b0;
    assign bus.mem_in  = empty ? EMPTY_VALUE : mem[rd_ptr];
`endif

    assign push   = bus.in_valid && bus.in_ready && !bypass_take;
    assign pop    = bus.rd_en && !empty;
    assign uf_set = bus.rd_en && empty && !bypass_take;

    // Storage is intentionally not reset.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            // DEPTH is 2**ADDR_W, so the natural pointer overflow is the wrap.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (uf_set)
                underflow <= 1'b1;
            else if (bus.clr_err)
                underflow <= 1'b0;
        end
    end

    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.count     = count;
    assign bus.underflow = underflow;

endmodule

// File: tb/tb_io_input_buffer.sv
// tb_io_input_buffer
//   Directed-vector bench for io_input_buffer. Inputs change 1 time unit after
//   the rising edge; outputs are sampled at that point (registered state) or
//   after a further 1 unit for same-cycle combinational checks.
module tb_io_input_buffer;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic CLK = 1'b0;
    logic reset;
    int   vecs = 0;
    int   errs = 0;

    io_input_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    io_input_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .EMPTY_VALUE(16'h0000)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic pop1();
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        vecs++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        step();
        vecs++; if (bus.mem_in !== 16'h0000) begin errs++; $display("FAIL rst_mem_in got=%h exp=0000", bus.mem_in); end
        vecs++; if (bus.empty !== 1'b1) begin errs++; $display("FAIL rst_empty got=%b exp=1", bus.empty); end
        vecs++; if (bus.full !== 1'b0) begin errs++; $display("FAIL rst_full got=%b exp=0", bus.full); end
        vecs++; if (bus.count !== 3'd0) begin errs++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
        vecs++; if (bus.underflow !== 1'b0) begin errs++; $display("FAIL rst_underflow got=%b exp=0", bus.underflow); end
        reset = 1'b0;
        #1;
        vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL post_rst_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_basic();
        push(16'h1234);
        vecs++; if (bus.mem_in !== 16'h1234) begin errs++; $display("FAIL basic_first got=%h exp=1234", bus.mem_in); end
        push(16'hABCD);
        vecs++; if (bus.mem_in !== 16'h1234) begin errs++; $display("FAIL basic_head got=%h exp=1234", bus.mem_in); end
        vecs++; if (bus.count !== 3'd2) begin errs++; $display("FAIL basic_count got=%0d exp=2", bus.count); end
        pop1();
        vecs++; if (bus.mem_in !== 16'hABCD) begin errs++; $display("FAIL basic_pop1 got=%h exp=abcd", bus.mem_in); end
        pop1();
        vecs++; if (bus.empty !== 1'b1) begin errs++; $display("FAIL basic_empty got=%b exp=1", bus.empty); end
        vecs++; if (bus.mem_in !== 16'h0000) begin errs++; $display("FAIL basic_mem_empty got=%h exp=0000", bus.mem_in); end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) push(16'(i));
        vecs++; if (bus.full !== 1'b1) begin errs++; $display("FAIL full_flag got=%b exp=1", bus.full); end
        vecs++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL full_in_ready got=%b exp=0", bus.in_ready); end
        vecs++; if (bus.count !== 3'd4) begin errs++; $display("FAIL full_count got=%0d exp=4", bus.count); end
        bus.in_data  = 16'h0005;
        bus.in_valid = 1'b1;
        step();
        vecs++; if (bus.count !== 3'd4) begin errs++; $display("FAIL full_refuse_count got=%0d exp=4", bus.count); end
        vecs++; if (bus.mem_in !== 16'h0001) begin errs++; $display("FAIL full_refuse_head got=%h exp=0001", bus.mem_in); end
        // Pop with push pending while full: only the pop happens.
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        vecs++; if (bus.count !== 3'd3) begin errs++; $display("FAIL full_pop_count got=%0d exp=3", bus.count); end
        vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL full_pop_ready got=%b exp=1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        vecs++; if (bus.count !== 3'd4) begin errs++; $display("FAIL full_accept5 got=%0d exp=4", bus.count); end
        for (int i = 2; i <= 5; i++) begin
            vecs++; if (bus.mem_in !== 16'(i)) begin errs++; $display("FAIL full_order got=%h exp=%h", bus.mem_in, 16'(i)); end
            pop1();
        end
        vecs++; if (bus.empty !== 1'b1) begin errs++; $display("FAIL full_drain_empty got=%b exp=1", bus.empty); end
    endtask

    task automatic test_underflow();
        pop1();
        vecs++; if (bus.underflow !== 1'b1) begin errs++; $display("FAIL uf_set got=%b exp=1", bus.underflow); end
        vecs++; if (bus.count !== 3'd0) begin errs++; $display("FAIL uf_count got=%0d exp=0", bus.count); end
        for (int i = 0; i < 5; i++) begin
            step();
            vecs++; if (bus.underflow !== 1'b1) begin errs++; $display("FAIL uf_hold got=%b exp=1", bus.underflow); end
        end
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        vecs++; if (bus.underflow !== 1'b0) begin errs++; $display("FAIL uf_clear got=%b exp=0", bus.underflow); end
        bus.clr_err = 1'b1;
        bus.rd_en   = 1'b1;
        step();
        bus.clr_err = 1'b0;
        bus.rd_en   = 1'b0;
        vecs++; if (bus.underflow !== 1'b1) begin errs++; $display("FAIL uf_set_wins got=%b exp=1", bus.underflow); end
        vecs++; if (bus.count !== 3'd0) begin errs++; $display("FAIL uf_count2 got=%0d exp=0", bus.count); end
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
    endtask

    task automatic test_back_to_back();
        push(16'hA000);
        push(16'hA001);
        for (int i = 0; i < 8; i++) begin
            bus.in_data  = 16'hA002 + 16'(i);
            bus.in_valid = 1'b1;
            bus.rd_en    = 1'b1;
            #1;
            vecs++; if (bus.mem_in !== 16'hA000 + 16'(i)) begin errs++; $display("FAIL b2b_order got=%h exp=%h", bus.mem_in, 16'hA000 + 16'(i)); end
            step();
            vecs++; if (bus.count !== 3'd2) begin errs++; $display("FAIL b2b_count got=%0d exp=2", bus.count); end
        end
        bus.in_valid = 1'b0;
        bus.rd_en    = 1'b0;
        vecs++; if (bus.mem_in !== 16'hA008) begin errs++; $display("FAIL b2b_tail0 got=%h exp=a008", bus.mem_in); end
        pop1();
        vecs++; if (bus.mem_in !== 16'hA009) begin errs++; $display("FAIL b2b_tail1 got=%h exp=a009", bus.mem_in); end
        pop1();
        vecs++; if (bus.empty !== 1'b1) begin errs++; $display("FAIL b2b_empty got=%b exp=1", bus.empty); end
        vecs++; if (bus.underflow !== 1'b0) begin errs++; $display("FAIL b2b_uf got=%b exp=0", bus.underflow); end
    endtask

    task automatic test_bypass();
        bus.in_data  = 16'hBEEF;
        bus.in_valid = 1'b1;
        bus.rd_en    = 1'b1;
        #1;
`ifdef IO_BYPASS_EN
        vecs++; if (bus.mem_in !== 16'hBEEF) begin errs++; $display("FAIL byp_same_cycle got=%h exp=beef", bus.mem_in); end
        step();
        bus.in_valid = 1'b0;
        bus.rd_en    = 1'b0;
        vecs++; if (bus.count !== 3'd0) begin errs++; $display("FAIL byp_count got=%0d exp=0", bus.count); end
        vecs++; if (bus.underflow !== 1'b0) begin errs++; $display("FAIL byp_uf got=%b exp=0", bus.underflow); end
`else
        vecs++; if (bus.mem_in !== 16'h0000) begin errs++; $display("FAIL nobyp_same_cycle got=%h exp=0000", bus.mem_in); end
        step();
        bus.in_valid = 1'b0;
        bus.rd_en    = 1'b0;
        vecs++; if (bus.count !== 3'd1) begin errs++; $display("FAIL nobyp_count got=%0d exp=1", bus.count); end
        vecs++; if (bus.underflow !== 1'b1) begin errs++; $display("FAIL nobyp_uf got=%b exp=1", bus.underflow); end
        vecs++; if (bus.mem_in !== 16'hBEEF) begin errs++; $display("FAIL nobyp_head got=%h exp=beef", bus.mem_in); end
`endif
    endtask

    task automatic test_mid_reset();
        push(16'h5555);
        push(16'h6666);
        reset = 1'b1;
        step();
        reset = 1'b0;
        vecs++; if (bus.count !== 3'd0) begin errs++; $display("FAIL midrst_count got=%0d exp=0", bus.count); end
        vecs++; if (bus.mem_in !== 16'h0000) begin errs++; $display("FAIL midrst_mem got=%h exp=0000", bus.mem_in); end
        vecs++; if (bus.underflow !== 1'b0) begin errs++; $display("FAIL midrst_uf got=%b exp=0", bus.underflow); end
        push(16'h7777);
        vecs++; if (bus.mem_in !== 16'h7777) begin errs++; $display("FAIL midrst_push got=%h exp=7777", bus.mem_in); end
    endtask

    initial begin
        reset        = 1'b1;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.rd_en    = 1'b0;
        bus.clr_err  = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_full();
        test_underflow();
        test_back_to_back();
        test_bypass();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
